// File: rtl/snn_layer_sequencer_pkg.sv
// snn_layer_sequencer_pkg: shared FSM state type and width helpers for the layer sequencer.
package snn_layer_sequencer_pkg;
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, NEXT, DONE} state_t;
    function automatic int clogb2(input int v);
        int r;
        r = 0;
        for (int t = v; t > 0; t = t >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction
    function automatic int lid_w(input int layers);
        return clogb2(layers - 1);
    endfunction
    function automatic int out_w(input int max_out);
        return clogb2(max_out);
    endfunction
endpackage

// File: rtl/snn_layer_sequencer_if.sv
// snn_layer_sequencer_if: beat handshake between sequencer, synapse stage and neuron.
interface snn_layer_sequencer_if import snn_layer_sequencer_pkg::*; #(
    parameter int LAYERS = 4,
    parameter int NEURON_W = 8
);
    localparam int LID_W = lid_w(LAYERS);
    logic syn_valid;
    logic syn_ready;
    logic en;
    logic voltage_ready;
    logic [LID_W-1:0] layer_id;
    logic [NEURON_W-1:0] neuron_idx;
    modport master (input syn_valid, voltage_ready, output syn_ready, en, layer_id, neuron_idx);
    modport slave (output syn_valid, voltage_ready, input syn_ready, en, layer_id, neuron_idx);
endinterface

// File: rtl/snn_layer_sequencer_outstanding_ctr.sv
// snn_outstanding_ctr: saturating count of issued-but-unretired beats with full/empty/underflow flags.
module snn_outstanding_ctr #(
    parameter int MAX = 4,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         full,
    output logic         empty,
    output logic         underflow
);
    assign full = cnt == W'(MAX);
    assign empty = cnt == '0;
    assign underflow = dec && empty;
    // a retire against an empty counter is stray and never cancels a same-cycle issue
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (inc && (!dec || empty) && !full) cnt <= cnt + W'(1);
        else if (dec && !inc && !empty) cnt <= cnt - W'(1);
endmodule

// File: rtl/snn_layer_sequencer.sv
// snn_layer_sequencer: walks layers per timestep, issuing neuron beats and draining them before advancing.
module snn_layer_sequencer import snn_layer_sequencer_pkg::*; #(
    parameter int LAYERS = 4,
    parameter int NEURON_W = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NEURON_W-1:0] n_neurons_1,
    input  logic [NEURON_W-1:0] n_neurons_2,
    input  logic [NEURON_W-1:0] n_neurons_3,
    input  logic [NEURON_W-1:0] n_neurons_4,
    snn_layer_sequencer_if.master nrn,
    output logic                busy,
    output logic                layer_done,
    output logic                done,
    output logic                err
);
    localparam int LID_W = lid_w(LAYERS);
    localparam int OUT_W = out_w(MAX_OUT);
    state_t state;
    logic [NEURON_W-1:0] issued;
    logic [NEURON_W-1:0] n_cur;
    logic [LID_W-1:0] lid;
    logic [OUT_W-1:0] outstanding;
    logic full, empty, underflow;
    assign n_cur = lid == LID_W'(0) ? n_neurons_1 :
                   lid == LID_W'(1) ? n_neurons_2 :
                   lid == LID_W'(2) ? n_neurons_3 : n_neurons_4;
    assign nrn.en = state == RUN && nrn.syn_valid && issued < n_cur && !full;
    assign nrn.syn_ready = nrn.en;
    assign nrn.layer_id = lid;
    assign nrn.neuron_idx = issued;
    snn_outstanding_ctr #(.MAX(MAX_OUT), .W(OUT_W)) u_out (
        .clk(clk),
        .rst(rst),
        .inc(nrn.en),
        .dec(nrn.voltage_ready),
        .cnt(outstanding),
        .full(full),
        .empty(empty),
        .underflow(underflow)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            issued <= '0;
            lid <= '0;
            busy <= 1'b0;
            layer_done <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            layer_done <= 1'b0;
            done <= 1'b0;
            if (underflow) err <= 1'b1;
            if (nrn.en) issued <= issued + NEURON_W'(1);
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    busy <= 1'b1;
                    err <= 1'b0;
                    issued <= '0;
                    lid <= '0;
                end
                RUN: if (issued == n_cur) state <= DRAIN;
                DRAIN: if (empty) begin
                    state <= NEXT;
                    layer_done <= 1'b1;
                end
                NEXT: begin
                    issued <= '0;
                    if (lid < LID_W'(LAYERS - 1)) begin
                        lid <= lid + LID_W'(1);
                        state <= RUN;
                    end else begin
                        state <= DONE;
                        done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    lid <= '0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_snn_layer_sequencer.sv
// tb_snn_layer_sequencer: directed and randomized timesteps checked against a per-layer beat accounting model.
module tb_snn_layer_sequencer;
    logic clk = 1'b0;
    logic rst, start;
    logic [7:0] n1, n2, n3, n4;
    logic busy, layer_done, done, err;
    snn_layer_sequencer_if nrn ();
    snn_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .n_neurons_1(n1), .n_neurons_2(n2), .n_neurons_3(n3), .n_neurons_4(n4),
        .nrn(nrn), .busy(busy), .layer_done(layer_done), .done(done), .err(err)
    );
    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    int q[$];
    int cexp[4];
    int en_cnt[4];
    int inflight, max_in, stray, idx_bad, order_bad, cnt_bad, rdy_bad, ld_cnt, done_cnt;
    int valid_pct = 100, lat = 2, release_cnt = 0;
    bit lat_rand = 0, hold = 0, force_vr = 0, pend_start = 0, start_on_done = 0;
    logic [1:0] prev_lid;
    logic prev_busy;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) en_cnt[i] = 0;
        max_in = 0; stray = 0; idx_bad = 0; order_bad = 0; cnt_bad = 0; rdy_bad = 0;
        ld_cnt = 0; done_cnt = 0; prev_lid = 2'd0; prev_busy = 1'b0;
    endtask

    task automatic set_counts(input int a, input int b, input int c, input int d);
        cexp[0] = a; cexp[1] = b; cexp[2] = c; cexp[3] = d;
        n1 = 8'(a); n2 = 8'(b); n3 = 8'(c); n4 = 8'(d);
    endtask

    // one clock: drive inputs on the falling edge, then account for what the sequencer did
    task automatic tick();
        int due;
        @(negedge clk);
        start = pend_start;
        pend_start = 0;
        nrn.syn_valid = int'($urandom_range(0, 99)) < valid_pct;
        nrn.voltage_ready = 1'b0;
        if (force_vr) nrn.voltage_ready = 1'b1;
        else if (q.size() > 0 && (hold ? release_cnt > 0 : q[0] <= cyc)) begin
            nrn.voltage_ready = 1'b1;
            void'(q.pop_front());
            if (hold) release_cnt--;
        end
        #1;
        if (!rst) begin
            if (int'(dut.u_out.cnt) != inflight) cnt_bad++;
            if (nrn.syn_ready !== nrn.en) rdy_bad++;
            if (busy && !prev_busy && nrn.layer_id != 2'd0) order_bad++;
            if (busy && prev_busy && nrn.layer_id != prev_lid &&
                (nrn.layer_id != prev_lid + 2'd1 || inflight != 0)) order_bad++;
            if (nrn.voltage_ready) begin
                if (inflight > 0) inflight--;
                else stray++;
            end
            if (nrn.en) begin
                if (int'(nrn.neuron_idx) != en_cnt[nrn.layer_id]) idx_bad++;
                en_cnt[nrn.layer_id]++;
                inflight++;
                if (inflight > max_in) max_in = inflight;
                due = cyc + (lat_rand ? int'($urandom_range(1, 6)) : lat);
                if (q.size() > 0 && due <= q[$]) due = q[$] + 1;
                q.push_back(due);
            end
            ld_cnt += int'(layer_done);
            done_cnt += int'(done);
            if (done && start_on_done) start = 1'b1;
            prev_lid = nrn.layer_id;
            prev_busy = busy;
        end
        cyc++;
    endtask

    task automatic run_done(input string tag, input int budget);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, done_cnt != d0, 1);
    endtask

    task automatic end_checks(input string tag);
        repeat (3) tick();
        for (int i = 0; i < 4; i++) chk($sformatf("%s_en_l%0d", tag, i), en_cnt[i], cexp[i]);
        chk({tag, "_layer_done"}, ld_cnt, 4);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_lid_after"}, nrn.layer_id, 0);
        chk({tag, "_protocol"}, idx_bad + order_bad + cnt_bad + rdy_bad + stray, 0);
        chk({tag, "_max_out"}, max_in <= 4, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        nrn.syn_valid = 1'b0; nrn.voltage_ready = 1'b0;
        inflight = 0;
        set_counts(0, 0, 0, 0);
        clear_stats();
        repeat (3) tick();
        chk("reset_outputs", {busy, layer_done, done, err, nrn.en, nrn.syn_ready, nrn.layer_id, nrn.neuron_idx}, 0);
        rst = 1'b0;
        tick();

        set_counts(3, 2, 1, 2);
        clear_stats();
        pend_start = 1;
        run_done("basic", 300);
        end_checks("basic");
        chk("basic_total", en_cnt[0] + en_cnt[1] + en_cnt[2] + en_cnt[3], 8);

        set_counts(6, 1, 1, 1);
        clear_stats();
        hold = 1; release_cnt = 0;
        pend_start = 1;
        repeat (20) tick();
        chk("bp_stall_en", en_cnt[0], 4);
        chk("bp_max_in", max_in, 4);
        chk("bp_busy", busy, 1);
        release_cnt = 1;
        repeat (10) tick();
        chk("bp_release_en", en_cnt[0], 5);
        hold = 0;
        run_done("bp", 300);
        end_checks("bp");

        set_counts(2, 0, 0, 1);
        clear_stats();
        pend_start = 1;
        run_done("skip", 300);
        end_checks("skip");

        set_counts(5, 5, 5, 5);
        lat = 1;
        clear_stats();
        pend_start = 1;
        repeat (4) tick();
        chk("same_cycle_out", dut.u_out.cnt, 1);
        chk("same_cycle_en", en_cnt[0], 3);
        run_done("same", 300);
        end_checks("same");
        lat = 2;

        force_vr = 1;
        tick();
        force_vr = 0;
        tick();
        chk("stray_err", err, 1);
        chk("stray_seen", stray, 1);
        set_counts(1, 0, 0, 0);
        clear_stats();
        pend_start = 1;
        repeat (2) tick();
        chk("stray_cleared", err, 0);
        run_done("stray", 300);
        end_checks("stray");

        lat_rand = 1;
        for (int r = 0; r < 4; r++) begin
            set_counts($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            valid_pct = $urandom_range(40, 100);
            clear_stats();
            pend_start = 1;
            run_done($sformatf("rand%0d", r), 2000);
            end_checks($sformatf("rand%0d", r));
        end
        lat_rand = 0;
        valid_pct = 100;

        set_counts(1, 1, 3, 1);
        lat = 4;
        clear_stats();
        pend_start = 1;
        begin
            int n = 0;
            while (!(nrn.layer_id == 2'd2 && en_cnt[2] == 3) && n < 300) begin
                tick();
                n++;
            end
        end
        hold = 1; release_cnt = 0;
        repeat (3) tick();
        chk("drain_lid", nrn.layer_id, 2);
        chk("drain_busy", busy, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        nrn.syn_valid = 1'b1;
        #1;
        chk("async_rst_outputs", {busy, layer_done, done, err, nrn.en, nrn.syn_ready, nrn.layer_id, nrn.neuron_idx}, 0);
        chk("async_rst_no_done", done_cnt, 0);
        q.delete();
        inflight = 0;
        hold = 0;
        repeat (2) tick();
        rst = 1'b0;
        lat = 2;
        clear_stats();
        pend_start = 1;
        run_done("after_rst", 300);
        end_checks("after_rst");

        set_counts(2, 3, 1, 2);
        lat_rand = 1;
        valid_pct = 70;
        clear_stats();
        pend_start = 1;
        repeat (6) tick();
        pend_start = 1;
        start_on_done = 1;
        run_done("restart", 500);
        end_checks("restart");
        start_on_done = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
